// File: rtl/key_debounce_repeat_pkg.sv
// key_debounce_repeat_pkg: board timing defaults and key FSM state encoding.
// Rev 1.0
`default_nettype none

package key_debounce_repeat_pkg;

  localparam int BOARD_CLK_HZ        = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = BOARD_CLK_HZ / 100;  // 10 ms
  localparam int DEF_REPEAT_DELAY    = BOARD_CLK_HZ / 2;    // 0.5 s
  localparam int DEF_REPEAT_PERIOD   = BOARD_CLK_HZ / 10;   // 0.1 s

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } key_state_t;

endpackage

`default_nettype wire

// File: rtl/key_debounce_repeat_sync.sv
// key_sync: two-flop synchroniser with asynchronous reset to a chosen level.
// Rev 1.0
`default_nettype none

module key_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat: debounced active-low key with press/release strobes and auto-repeat.
// Rev 1.0
`default_nettype none

module key_debounce_repeat
  import key_debounce_repeat_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic in_key,
  output logic out_key,
  output logic out_release,
  output logic out_held
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  logic             pressed_s;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_nxt;
  logic             db_done;
  logic             press_acc;
  logic             rel_acc;
  logic             key_nxt;
  logic             rel_nxt;
  key_state_t       state;
  key_state_t       state_nxt;

  // Key is active-low; synchronise the pressed level so reset means "released".
  key_sync #(.RESET_VAL(1'b0)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (~in_key),
    .q   (pressed_s)
  );

  assign db_done   = (pressed_s != out_held) && (db_cnt == DB_LAST);
  assign press_acc = db_done && pressed_s;
  assign rel_acc   = db_done && !pressed_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      out_held <= 1'b0;
    end else if (pressed_s == out_held) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      out_held <= pressed_s;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rep_cnt     <= '0;
      out_key     <= 1'b0;
      out_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      rep_cnt     <= rep_nxt;
      out_key     <= key_nxt;
      out_release <= rel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (press_acc) state_nxt = HELD_DELAY;
      HELD_DELAY: begin
        if (rel_acc)
          state_nxt = IDLE;
        else if (REPEAT_EN && rep_cnt == RD_LAST)
          state_nxt = HELD_REPEAT;
      end
      HELD_REPEAT: if (rel_acc) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Release is checked first so it wins over a coincident repeat terminal count.
  always_comb begin
    key_nxt = 1'b0;
    rel_nxt = 1'b0;
    rep_nxt = rep_cnt;
    case (state)
      IDLE: begin
        if (press_acc) begin
          key_nxt = 1'b1;
          rep_nxt = '0;
        end
      end
      HELD_DELAY: begin
        if (rel_acc) begin
          rel_nxt = 1'b1;
          rep_nxt = '0;
        end else if (!REPEAT_EN) begin
          rep_nxt = '0;
        end else if (rep_cnt == RD_LAST) begin
          key_nxt = 1'b1;
          rep_nxt = '0;
        end else begin
          rep_nxt = rep_cnt + 1'b1;
        end
      end
      HELD_REPEAT: begin
        if (rel_acc) begin
          rel_nxt = 1'b1;
          rep_nxt = '0;
        end else if (rep_cnt == RP_LAST) begin
          key_nxt = 1'b1;
          rep_nxt = '0;
        end else begin
          rep_nxt = rep_cnt + 1'b1;
        end
      end
      default: rep_nxt = '0;
    endcase
  end

endmodule

`default_nettype wire
